// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Used by mem_port_arbiter and rr_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N (rotate, priority-encode, un-rotate).
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    parameter int W = clog2(DEF_NUM_REQ)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] winner
);

    int idx;

    // Descending scan so the nearest requester above ptr is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                found  = 1'b1;
                winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory/register-file port.
// Optional forced release after TIMEOUT_CYCLES: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SEL_WIDTH      = clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 busy
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    state_t               state, state_n;
    logic [SEL_WIDTH-1:0] ptr, ptr_n, sel_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic                 found;
    logic [SEL_WIDTH-1:0] winner;
    logic                 tmo_hit;

    rr_pick #(
        .N (NUM_REQ),
        .W (SEL_WIDTH)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt;

    assign tmo_hit = (state == GRANT) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside GRANT, so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= (state == GRANT) ? cnt + CW'(1) : '0;
            timeout <= tmo_hit && !done && req[sel];
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        gnt_n   = gnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    sel_n   = winner;
                    gnt_n   = NUM_REQ'(1) << winner;
                end
            end
            GRANT: begin
                if (done || !req[sel] || tmo_hit) begin
                    state_n = RELEASE;
                    gnt_n   = '0;
                    ptr_n   = (sel == SEL_WIDTH'(NUM_REQ - 1))
                              ? '0 : sel + SEL_WIDTH'(1);
                end
            end
            RELEASE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == GRANT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Build with MEM_ARB_TIMEOUT_EN to exercise the forced-release path.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .NUM_REQ        (4),
        .SEL_WIDTH      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag,
                             input logic [3:0] e_gnt,
                             input logic [1:0] e_sel,
                             input logic e_busy);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        logic [1:0] order [5];
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
        order[3] = 2'd3;
        order[4] = 2'd0;

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
        check("reset.timeout", 32'(timeout), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle_noreq", 4'b0000, 2'd0, 1'b0);
        end

        // done while idle is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        check_out("idle_done", 4'b0000, 2'd0, 1'b0);

        req = 4'b1010;
        step();
        check_out("rr_first", 4'b0010, 2'd1, 1'b1);
        step();
        check_out("rr_hold", 4'b0010, 2'd1, 1'b1);
        done = 1'b1;
        req  = 4'b1000;
        step();
        done = 1'b0;
        check_out("rr_release", 4'b0000, 2'd1, 1'b0);
        step();
        check_out("rr_idle", 4'b0000, 2'd1, 1'b0);
        step();
        check_out("rr_second", 4'b1000, 2'd3, 1'b1);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        step();
        check_out("rr_drain", 4'b0000, 2'd3, 1'b0);

        // ptr wrapped to 0 after sel=3
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("rot%0d.grant", k),
                      4'b0001 << order[k], order[k], 1'b1);
            step();
            check_out($sformatf("rot%0d.hold", k),
                      4'b0001 << order[k], order[k], 1'b1);
            done = 1'b1;
            step();
            done = 1'b0;
            check_out($sformatf("rot%0d.rel", k), 4'b0000, order[k], 1'b0);
            step();
            check_out($sformatf("rot%0d.idle", k), 4'b0000, order[k], 1'b0);
        end

        req = 4'b0100;
        step();
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1);
        req = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("post_rst", 4'b0001, 2'd0, 1'b1);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        step();

        // abandon: req[1] drops without done
        req = 4'b0010;
        step();
        check_out("ab_grant", 4'b0010, 2'd1, 1'b1);
        req = 4'b0101;
        step();
        check_out("ab_release", 4'b0000, 2'd1, 1'b0);
        step();
        check_out("ab_idle", 4'b0000, 2'd1, 1'b0);
        step();
        check_out("ab_next", 4'b0100, 2'd2, 1'b1);

`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            check_out($sformatf("tmo_hold%0d", i), 4'b0100, 2'd2, 1'b1);
            check($sformatf("tmo_quiet%0d", i), 32'(timeout), 32'd0);
        end
        step();
        check_out("tmo_fire", 4'b0000, 2'd2, 1'b0);
        check("tmo_pulse", 32'(timeout), 32'd1);
        step();
        check("tmo_end", 32'(timeout), 32'd0);
`else
        for (int i = 1; i <= 110; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b1);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        check_out("hold_done", 4'b0000, 2'd2, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
